simon_key_expander: RTL
=======================

SIMON_KEY_EXPANDER -- requirements
Module: simon_key_expander

Interface
REQ-001 SHALL have parameter N, default 16, word width in bits; legal values 16, 24, 32, 48, 64.
REQ-002 SHALL have parameter M, default 4, number of key words; legal values 2, 3, 4.
REQ-003 SHALL have parameter T, default 32, total round keys to emit; legal range M+1 to 255.
REQ-004 SHALL have parameter Z_IDX, default 0, selecting Simon constant sequence z0..z4.
REQ-005 SHALL have port clk, input, width 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-007 SHALL have port start, input, width 1: request a new expansion; sampled only in IDLE.
REQ-008 SHALL have port abort, input, width 1: terminate the expansion in progress.
REQ-009 SHALL have port key, input, width N*M: master key; k0 = key[N-1:0], k(M-1) = key[N*M-1:N*(M-1)].
REQ-010 SHALL have port rk_data, output, width N: current round key.
REQ-011 SHALL have port rk_idx, output, width 8: index of rk_data, 0..T-1.
REQ-012 SHALL have port rk_valid, output, width 1: rk_data/rk_idx are valid.
REQ-013 SHALL have port rk_ready, input, width 1: consumer accepts; a transfer occurs when rk_valid and rk_ready are both 1.
REQ-014 SHALL have port busy, output, width 1: high while in RUN.
REQ-015 SHALL have port done, output, width 1: one-cycle pulse after the final transfer.

Function
REQ-016 SHALL implement a two-state FSM: IDLE and RUN.
REQ-017 IDLE with start=1 and abort=0 SHALL load k0..k(M-1) into an M-word window, clear the index to 0 and enter RUN; start in RUN SHALL be ignored.
REQ-018 In RUN, rk_valid SHALL be 1, and rk_data SHALL equal window word 0 with rk_idx equal to the index; the first key SHALL be visible the cycle after start is accepted.
REQ-019 rk_data and rk_idx SHALL hold stable while rk_valid=1 and rk_ready=0.
REQ-020 On each transfer, the window SHALL shift down one word, the new top word SHALL be k(i), with i = index+M, and the index SHALL increment; the next key SHALL follow with zero bubbles, giving one key per cycle when rk_ready stays high.
REQ-021 k(i) SHALL be computed as follows, using rotate-right on N bits, with Sr as rotate right:
- tmp = Sr3(k(i-1)); if M=4, tmp ^= k(i-3); then tmp ^= Sr1(tmp).
- k(i) = ~k(i-M) ^ tmp ^ z[(i-M) mod 62] ^ 3.
REQ-022 z[j] SHALL be bit j of the Z_IDX-selected 62-element Simon sequence, counted left to right; z0 = 11111010001001010110000111001101111101000100101011000011100110, and z1..z4 SHALL be as in the Simon specification.
REQ-023 The (i-M) mod 62 index SHALL use a 6-bit counter that wraps from 61 to 0, with no divider.
REQ-024 The transfer of rk_idx = T-1 SHALL return the FSM to IDLE, drop rk_valid and busy the next cycle, and assert done for exactly that cycle.
REQ-025 start SHALL be accepted in the same cycle done is high, since the FSM is in IDLE.
REQ-026 abort=1 in RUN SHALL return the FSM to IDLE next cycle with rk_valid=0 and no done pulse; a transfer in the same cycle SHALL still count, but no further keys SHALL be issued.
REQ-027 abort=1 with start=1 in IDLE SHALL take priority: no load, and the FSM stays in IDLE.
REQ-028 A change on key while in RUN SHALL have no effect.

Reset
REQ-029 rst=1 SHALL force IDLE, rk_valid=0, busy=0, done=0, rk_idx=0, rk_data=0 and window=0 at the next edge, including mid-expansion, and SHALL override start and abort.
REQ-030 The first start SHALL be accepted in the first cycle with rst=0.

Verification
REQ-031 Test Simon32/64 (defaults) with key=64'h1918111009080100, start pulse, rk_ready=1: rk_data sequence 0100, 0908, 1110, 1918, 71C3 at idx 0..4, 32 keys on consecutive cycles, and done one cycle after idx 31.
REQ-032 Test backpressure with rk_ready toggled pseudo-randomly: the key sequence is identical to REQ-031, with data held during stalls and no keys skipped or duplicated.
REQ-033 Test abort at idx 10 with rk_ready=0: rk_valid=0 next cycle, no done, busy=0; then start again and observe idx 0 = 0100.
REQ-034 Test rst asserted at idx 20: all outputs zero next cycle; after release, start yields a full 32-key sequence.
REQ-035 Test start held high through RUN and done: a second expansion begins in the done cycle with no lost cycle; test start+abort in IDLE: no expansion.
REQ-036 Test N=64, M=2, Z_IDX=2, T=68: 68 keys with z index wrap at key 64 (j=62 maps to z[0]), with results matching a software Simon128/128 model.

Source files
------------

// File: rtl/simon_key_expander.sv
// Simon key-schedule expander: streams T round keys from an M-word master key over a valid/ready port.
// First key appears the cycle after start is accepted; one key per cycle while rk_ready is held, holds on stall.
module simon_key_expander #(
  parameter int N     = 16,
  parameter int M     = 4,
  parameter int T     = 32,
  parameter int Z_IDX = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic [N*M-1:0] key,
  output logic [N-1:0]   rk_data,
  output logic [7:0]     rk_idx,
  output logic           rk_valid,
  input  logic           rk_ready,
  output logic           busy,
  output logic           done
);

  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101100;
  localparam logic [61:0] ZSEQ = (Z_IDX == 0) ? Z0 : (Z_IDX == 1) ? Z1 :
                                 (Z_IDX == 2) ? Z2 : (Z_IDX == 3) ? Z3 : Z4;
  localparam logic [7:0]   LAST_IDX = 8'(T - 1);
  localparam logic [N-1:0] RC       = N'(3);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e               state_q, state_d;
  logic [M-1:0][N-1:0]  win_q, win_d;
  logic [7:0]           idx_q;
  logic [5:0]           zc_q, zc_d;
  logic                 done_q, done_d;
  logic                 load, xfer, last;
  logic [N-1:0]         tmp, k_new;
  logic                 z_bit;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    xfer    = 1'b0;
    last    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          load    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        xfer = rk_ready;
        last = rk_ready && (idx_q == LAST_IDX);
        if (abort || last) state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    rk_valid = (state_q == S_RUN);
    busy     = (state_q == S_RUN);
    done     = done_q;
    rk_data  = win_q[0];
    rk_idx   = idx_q;
  end

  // Window word 0 is k(i-M), word M-1 is k(i-1); zc_q tracks (i-M) mod 62.
  assign z_bit = ZSEQ[6'd61 - zc_q];
  assign zc_d  = (zc_q == 6'd61) ? 6'd0 : zc_q + 6'd1;

  always_comb begin
    tmp = {win_q[M-1][2:0], win_q[M-1][N-1:3]};
    if (M == 4) tmp = tmp ^ win_q[1];
    tmp   = tmp ^ {tmp[0], tmp[N-1:1]};
    k_new = ~win_q[0] ^ tmp ^ {{(N-1){1'b0}}, z_bit} ^ RC;
  end

  assign win_d  = {k_new, win_q[M-1:1]};
  assign done_d = last && !abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q  <= '0;
      idx_q  <= '0;
      zc_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
      if (load) begin
        win_q <= key;
        idx_q <= '0;
        zc_q  <= '0;
      end else if (xfer && !last) begin
        win_q <= win_d;
        idx_q <= idx_q + 8'd1;
        zc_q  <= zc_d;
      end
    end
  end

endmodule
